// File: rtl/spisd_pkg.sv
// spisd_pkg: shared command/token constants, R1 helper and FSM states for the SPI SD card responder
package spisd_pkg;
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD8 = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD24 = 6'd24;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam logic [7:0] TOK_START = 8'hFE;
  localparam logic [7:0] TOK_DRESP = 8'h05;
  localparam int R1_IDLE_BIT = 0;
  localparam int R1_ILLEGAL_BIT = 2;
  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_NCR, S_RESP, S_TAIL, S_GAP, S_RTOKEN,
    S_RDATA, S_RCRC, S_WTOKEN, S_WDATA, S_WCRC, S_DRESP, S_BUSY
  } state_t;
  function automatic logic [7:0] r1_of(input logic idle_bit, input logic illegal);
    r1_of = 8'h00;
    r1_of[R1_IDLE_BIT] = idle_bit;
    r1_of[R1_ILLEGAL_BIT] = illegal;
  endfunction
endpackage

// File: rtl/spisd_byte_slave.sv
// spisd_byte_slave: SPI mode-0 byte shifter with input synchronizers and sclk edge detection
module spisd_byte_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       csn,
  input  logic       mosi,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       cs_active,
  output logic       miso
);
  logic [2:0] sclk_s;
  logic [1:0] csn_s;
  logic [1:0] mosi_s;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh;
  logic rise;
  logic fall;
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign fall = ~sclk_s[1] & sclk_s[2];
  assign cs_active = ~csn_s[1];
  assign miso = (csn | ~cs_active) ? 1'b1 : tx_sh[7];
  // two-stage synchronizers; sclk keeps a third stage as the previous value for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_s <= 3'b000;
      csn_s <= 2'b11;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      csn_s <= {csn_s[0], csn};
      mosi_s <= {mosi_s[0], mosi};
    end
  // sample mosi on rise, load or shift the transmit byte on fall; everything clears while deselected
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_byte <= 8'h00;
      rx_valid <= 1'b0;
      bit_cnt <= 3'd0;
      tx_sh <= 8'hFF;
    end else if (!cs_active) begin
      rx_valid <= 1'b0;
      bit_cnt <= 3'd0;
      tx_sh <= 8'hFF;
    end else begin
      rx_valid <= rise && bit_cnt == 3'd7;
      if (rise) begin
        rx_byte <= {rx_byte[6:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall) tx_sh <= bit_cnt == 3'd0 ? tx_byte : {tx_sh[6:0], 1'b1};
    end
endmodule

// File: rtl/spisd_card_responder.sv
// spisd_card_responder: SPI-mode SD card target with command decode, R1/R3/R7 replies and single-block transfers
module spisd_card_responder
  import spisd_pkg::*;
#(
  parameter int NCR = 1,
  parameter int NAC = 2,
  parameter int BUSY_BYTES = 4,
  parameter int INIT_POLLS = 2,
  parameter logic [31:0] OCR = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  output logic [8:0]  buf_addr,
  output logic        buf_rd,
  input  logic [7:0]  buf_rdata,
  output logic        buf_wr,
  output logic [7:0]  buf_wdata,
  output logic [31:0] blk_addr,
  output logic        blk_rd_start,
  output logic        blk_wr_done,
  output logic        idle
);
  state_t state, state_nx;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic rx_valid;
  logic cs_active;
  logic [5:0] cmd_idx;
  logic [31:0] arg;
  logic [31:0] tail;
  logic [9:0] cnt;
  logic [7:0] polls;
  logic [7:0] r1;
  logic [7:0] dout;
  logic [7:0] pf;
  logic app;
  logic is_rd;
  logic is_wr;
  logic has_tail;
  logic rd_q;

  spisd_byte_slave u_byte (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .csn(csn),
    .mosi(mosi),
    .tx_byte(tx_byte),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .cs_active(cs_active),
    .miso(miso)
  );

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_HUNT;
    else state <= state_nx;

  // next state advances once per exchanged byte; the transmit byte follows the current state
  always_comb begin
    state_nx = state;
    tx_byte = 8'hFF;
    case (state)
      S_HUNT: if (rx_valid && rx_byte[7:6] == 2'b01) state_nx = S_CMD;
      S_CMD: if (rx_valid && cnt == 10'd4) state_nx = rx_byte[0] ? S_NCR : S_HUNT;
      S_NCR: if (rx_valid && cnt == 10'(NCR - 1)) state_nx = S_RESP;
      S_RESP: begin
        tx_byte = r1;
        if (rx_valid) state_nx = has_tail ? S_TAIL : is_rd ? S_GAP : is_wr ? S_WTOKEN : S_HUNT;
      end
      S_TAIL: begin
        tx_byte = tail[31:24];
        if (rx_valid && cnt == 10'd3) state_nx = S_HUNT;
      end
      S_GAP: if (rx_valid && cnt == 10'(NAC - 1)) state_nx = S_RTOKEN;
      S_RTOKEN: begin
        tx_byte = TOK_START;
        if (rx_valid) state_nx = S_RDATA;
      end
      S_RDATA: begin
        tx_byte = dout;
        if (rx_valid && cnt == 10'd511) state_nx = S_RCRC;
      end
      S_RCRC: if (rx_valid && cnt == 10'd1) state_nx = S_HUNT;
      S_WTOKEN: if (rx_valid && rx_byte == TOK_START) state_nx = S_WDATA;
      S_WDATA: if (rx_valid && cnt == 10'd511) state_nx = S_WCRC;
      S_WCRC: if (rx_valid && cnt == 10'd1) state_nx = S_DRESP;
      S_DRESP: begin
        tx_byte = TOK_DRESP;
        if (rx_valid) state_nx = S_BUSY;
      end
      S_BUSY: begin
        tx_byte = 8'h00;
        if (rx_valid && cnt == 10'(BUSY_BYTES - 1)) state_nx = S_HUNT;
      end
      default: state_nx = S_HUNT;
    endcase
    if (!cs_active) state_nx = S_HUNT;
  end

  // command decode, card status, buffer prefetch and write strobes, all stepped on received bytes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_idx <= 6'd0;
      arg <= 32'h0;
      tail <= 32'h0;
      cnt <= 10'd0;
      polls <= 8'd0;
      r1 <= 8'hFF;
      dout <= 8'hFF;
      pf <= 8'hFF;
      app <= 1'b0;
      is_rd <= 1'b0;
      is_wr <= 1'b0;
      has_tail <= 1'b0;
      rd_q <= 1'b0;
      idle <= 1'b1;
      blk_addr <= 32'h0;
      buf_addr <= 9'd0;
      buf_rd <= 1'b0;
      buf_wr <= 1'b0;
      buf_wdata <= 8'h00;
      blk_rd_start <= 1'b0;
      blk_wr_done <= 1'b0;
    end else begin
      buf_rd <= 1'b0;
      buf_wr <= 1'b0;
      blk_rd_start <= 1'b0;
      blk_wr_done <= 1'b0;
      rd_q <= buf_rd;
      if (rd_q) pf <= buf_rdata;
      if (rx_valid) begin
        cnt <= state_nx != state ? 10'd0 : cnt + 10'd1;
        if (state == S_HUNT) cmd_idx <= rx_byte[5:0];
        if (state == S_CMD && cnt < 10'd4) arg <= {arg[23:0], rx_byte};
        if (state == S_CMD && state_nx == S_NCR) begin
          app <= cmd_idx == CMD55;
          has_tail <= 1'b0;
          is_rd <= 1'b0;
          is_wr <= 1'b0;
          case (cmd_idx)
            CMD0: begin
              idle <= 1'b1;
              polls <= 8'd0;
              r1 <= r1_of(1'b1, 1'b0);
            end
            CMD8: begin
              r1 <= r1_of(idle, 1'b0);
              tail <= {20'h0, arg[11:0]};
              has_tail <= 1'b1;
            end
            CMD55: r1 <= r1_of(idle, 1'b0);
            CMD41:
              if (!app) r1 <= r1_of(idle, 1'b1);
              else if (polls < 8'(INIT_POLLS)) begin
                polls <= polls + 8'd1;
                r1 <= r1_of(1'b1, 1'b0);
              end else begin
                idle <= 1'b0;
                r1 <= r1_of(1'b0, 1'b0);
              end
            CMD58: begin
              r1 <= r1_of(idle, 1'b0);
              tail <= OCR;
              has_tail <= 1'b1;
            end
            CMD17, CMD24:
              if (idle) r1 <= r1_of(1'b1, 1'b1);
              else begin
                r1 <= r1_of(1'b0, 1'b0);
                blk_addr <= arg;
                is_rd <= cmd_idx == CMD17;
                is_wr <= cmd_idx == CMD24;
              end
            default: r1 <= r1_of(idle, 1'b1);
          endcase
        end
        if (state == S_RESP && is_rd) blk_rd_start <= 1'b1;
        if (state == S_TAIL) tail <= {tail[23:0], 8'h00};
        if (state == S_GAP && state_nx == S_RTOKEN) begin
          buf_addr <= 9'd0;
          buf_rd <= 1'b1;
        end
        if (state == S_RTOKEN || state == S_RDATA) dout <= pf;
        if (state == S_RTOKEN || (state == S_RDATA && cnt < 10'd510)) begin
          buf_addr <= buf_addr + 9'd1;
          buf_rd <= 1'b1;
        end
        if (state == S_WDATA) begin
          buf_wr <= 1'b1;
          buf_wdata <= rx_byte;
          buf_addr <= cnt[8:0];
          blk_wr_done <= cnt == 10'd511;
        end
      end
    end
endmodule

// File: tb/tb_spisd_card_responder.sv
// tb_spisd_card_responder: scoreboard bench driving SPI frames and checking every miso byte and buffer traffic
module tb_spisd_card_responder;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic csn = 1'b1;
  logic mosi = 1'b1;
  logic miso;
  logic [8:0] buf_addr;
  logic buf_rd;
  logic [7:0] buf_rdata = 8'h00;
  logic buf_wr;
  logic [7:0] buf_wdata;
  logic [31:0] blk_addr;
  logic blk_rd_start;
  logic blk_wr_done;
  logic idle;
  logic [7:0] mem [512];
  logic [7:0] exp_q [$];
  logic [7:0] sh = 8'h00;
  logic [7:0] mon_exp;
  int nb = 0;
  int byte_no = 0;
  int checks = 0;
  int errors = 0;
  int rd_starts = 0;
  int wr_dones = 0;
  int wr_total = 0;
  int wr_base = 0;

  spisd_card_responder dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .csn(csn),
    .mosi(mosi),
    .miso(miso),
    .buf_addr(buf_addr),
    .buf_rd(buf_rd),
    .buf_rdata(buf_rdata),
    .buf_wr(buf_wr),
    .buf_wdata(buf_wdata),
    .blk_addr(blk_addr),
    .blk_rd_start(blk_rd_start),
    .blk_wr_done(blk_wr_done),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // buffer read port: data one clk after the strobe
  always @(posedge clk) if (buf_rd) buf_rdata <= mem[buf_addr];

  // buffer write port, write address order and pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (buf_wr) begin
      checks++;
      if (buf_addr !== 9'(wr_total - wr_base)) begin
        errors++;
        $display("FAIL wr_addr: got %0d expected %0d", buf_addr, 9'(wr_total - wr_base));
      end
      mem[buf_addr] = buf_wdata;
      wr_total++;
    end
    if (blk_rd_start) rd_starts++;
    if (blk_wr_done) wr_dones++;
  end

  // scoreboard monitor: assemble miso bytes as the host samples them and pop the expected value
  always @(posedge sclk) if (!csn) begin
    sh = {sh[6:0], miso};
    nb++;
    if (nb == 8) begin
      nb = 0;
      byte_no++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL miso_byte %0d: got %02h with no expectation queued", byte_no, sh);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sh !== mon_exp) begin
          errors++;
          $display("FAIL miso_byte %0d: got %02h expected %02h", byte_no, sh, mon_exp);
        end
      end
    end
  end

  always @(posedge csn) nb = 0;

  task automatic xfer(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [5:0] c, input logic [31:0] a, input logic [7:0] crc);
    xfer({2'b01, c}, 8'hFF);
    for (int i = 3; i >= 0; i--) xfer(a[8*i +: 8], 8'hFF);
    xfer(crc, 8'hFF);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    repeat (4) @(negedge clk);
    chk("reset_miso", {31'h0, miso}, 32'h1);
    chk("reset_idle", {31'h0, idle}, 32'h1);
    chk("reset_blk_addr", blk_addr, 32'h0);
    chk("reset_buf_addr", {23'h0, buf_addr}, 32'h0);
    chk("reset_strobes", {28'h0, buf_rd, buf_wr, blk_rd_start, blk_wr_done}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    csn = 1'b0;
    repeat (4) @(negedge clk);
    frame(6'd0, 32'h0, 8'h95);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h01);
    chk("cmd0_idle", {31'h0, idle}, 32'h1);
    frame(6'd8, 32'h000001AA, 8'h87);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h01);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'h01);
    xfer(8'hFF, 8'hAA);
    frame(6'd17, 32'h200, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h05);
    xfer(8'hFF, 8'hFF);
    chk("cmd17_idle_no_start", 32'(rd_starts), 32'd0);
    chk("cmd17_idle_blk_addr", blk_addr, 32'h0);
    frame(6'd0, 32'h0, 8'h94);
    repeat (3) xfer(8'hFF, 8'hFF);
    frame(6'd0, 32'h0, 8'h95);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h01);
    for (int p = 0; p < 3; p++) begin
      frame(6'd55, 32'h0, 8'h65);
      xfer(8'hFF, 8'hFF);
      xfer(8'hFF, 8'h01);
      frame(6'd41, 32'h40000000, 8'h77);
      xfer(8'hFF, 8'hFF);
      xfer(8'hFF, p < 2 ? 8'h01 : 8'h00);
      chk("acmd41_idle", {31'h0, idle}, p < 2 ? 32'h1 : 32'h0);
    end
    frame(6'd58, 32'h0, 8'hFD);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hC0);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h80);
    xfer(8'hFF, 8'h00);
    frame(6'd17, 32'h200, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFE);
    for (int i = 0; i < 512; i++) xfer(8'hFF, 8'(i));
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    chk("read_blk_addr", blk_addr, 32'h200);
    chk("read_start_pulses", 32'(rd_starts), 32'd1);
    chk("read_no_writes", 32'(wr_total), 32'd0);
    wr_base = wr_total;
    frame(6'd24, 32'h300, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFE, 8'hFF);
    repeat (512) xfer(8'hA5, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h05);
    repeat (4) xfer(8'hFF, 8'h00);
    xfer(8'hFF, 8'hFF);
    chk("write_count", 32'(wr_total - wr_base), 32'd512);
    chk("write_done_pulses", 32'(wr_dones), 32'd1);
    chk("write_blk_addr", blk_addr, 32'h300);
    chk("write_mem0", {24'h0, mem[0]}, 32'hA5);
    chk("write_mem511", {24'h0, mem[511]}, 32'hA5);
    wr_base = wr_total;
    frame(6'd24, 32'h400, 8'hFF);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h00);
    xfer(8'hFE, 8'hFF);
    repeat (100) xfer(8'h5A, 8'hFF);
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (10) @(negedge clk);
    chk("abandon_miso_high", {31'h0, miso}, 32'h1);
    csn = 1'b0;
    repeat (4) @(negedge clk);
    chk("abandon_count", 32'(wr_total - wr_base), 32'd100);
    chk("abandon_no_done", 32'(wr_dones), 32'd1);
    chk("abandon_idle_kept", {31'h0, idle}, 32'h0);
    chk("abandon_blk_addr", blk_addr, 32'h400);
    chk("abandon_mem99", {24'h0, mem[99]}, 32'h5A);
    chk("abandon_mem100", {24'h0, mem[100]}, 32'hA5);
    frame(6'd0, 32'h0, 8'h95);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, 8'h01);
    chk("final_cmd0_idle", {31'h0, idle}, 32'h1);
    repeat (8) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spisd_card_responder.md
Name: spisd_card_responder

Overview:
- SPI-mode SD card target: the card end of the host command/data transmitter.
- Decodes 6-byte command frames from the host, returns R1/R3/R7 responses, serves single-block reads (CMD17) and accepts single-block writes (CMD24) through a 512-byte buffer port.
- Used as a synthesizable card emulator and as the bench target for the host SPI SD path.

Parameters:
NCR, 1, number of 0xFF bytes between the last command byte and the response (1..8)
NAC, 2, number of 0xFF bytes between R1 and the 0xFE read token
BUSY_BYTES, 4, number of 0x00 busy bytes after the write data response
INIT_POLLS, 2, number of ACMD41 commands answered 0x01 before returning 0x00
OCR, 32'hC0FF8000, OCR value returned by CMD58

Ports:
clk  in  1  system clock, at least 8x the sclk frequency
rst  in  1  reset; asynchronous, active-high
sclk  in  1  SPI clock from host, mode 0, asynchronous to clk
csn  in  1  chip select, active low
mosi  in  1  serial data from host
miso  out  1  serial data to host
buf_addr  out  9  buffer byte address
buf_rd  out  1  buffer read strobe; buf_rdata is valid 1 clk later
buf_rdata  in  8  buffer read data
buf_wr  out  1  buffer write strobe
buf_wdata  out  8  buffer write data
blk_addr  out  32  argument latched from the last CMD17/CMD24
blk_rd_start  out  1  1-clk pulse when a CMD17 is accepted
blk_wr_done  out  1  1-clk pulse after the 512th write byte is stored
idle  out  1  card idle flag (R1 bit 0)

Behaviour:
- Reset values:
  - miso=1; all strobes and pulses 0; buf_addr=0; blk_addr=0; idle=1.
  - ACMD41 poll count=0; app flag=0; FSM in HUNT.
- Byte engine:
  - sclk, csn and mosi pass through 2-FF synchronizers before edge detection.
  - mosi is sampled on sclk rise, MSB first.
  - rx_valid pulses 1 clk after the 8th rise.
  - The next tx byte must be presented within 2 clk of rx_valid. It is loaded on the next sclk fall, and miso shifts on each fall.
  - While csn is high, miso=1.
- csn deassertion at any point:
  - Bit counter cleared, FSM to HUNT, buffer strobes cease.
  - idle, the poll count and blk_addr are retained.
  - An in-progress write is abandoned and blk_wr_done is not pulsed.
- Transmit byte is 0xFF in every state not listed below.
- HUNT: a received byte with [7:6]=01 starts a frame. Its index is cmd[5:0]; go to CMD.
- CMD: collect 4 argument bytes plus 1 CRC byte. The CRC is ignored.
  - If the final byte's bit0 is 0, the frame is bad: return to HUNT with no response.
  - Otherwise go to NCR.
- NCR: send NCR bytes of 0xFF, then RESP.
- R1 selection:
  - CMD0: idle=1, poll count=0, R1=0x01.
  - CMD8: R1 = {7'b0, idle}, then tail bytes 0x00, 0x00, arg[11:8], arg[7:0].
  - CMD55: app flag set, R1 = {7'b0, idle}.
  - ACMD41 (CMD41 with app flag set):
    - Poll count below INIT_POLLS: increment, R1=0x01.
    - Otherwise: idle=0, R1=0x00.
  - CMD58: R1 = {7'b0, idle}, then the 4 OCR bytes MSB first.
  - CMD17 or CMD24 while idle=0: R1=0x00 and blk_addr=arg.
  - Anything else, including CMD17/CMD24 while idle=1: R1 = 0x04 | idle.
  - The app flag clears on every command other than CMD55.
- Read path (CMD17):
  - Pulse blk_rd_start when R1 is sent.
  - Send NAC bytes of 0xFF, then 0xFE, then buffer bytes 0..511, then 0xFF, 0xFF as CRC, then HUNT.
  - buf_rd for byte k is issued during transmission of byte k-1, so no bubbles occur.
- Write path (CMD24):
  - After R1, ignore received bytes until 0xFE arrives. While waiting, 0xFF does not time out.
  - Store the next 512 bytes: buf_wr on rx_valid, buf_addr 0..511, address increments after each write.
  - Discard 2 CRC bytes.
  - Pulse blk_wr_done on the 512th write.
  - Send data response 0x05, then BUSY_BYTES bytes of 0x00, then return to HUNT sending 0xFF.
- Counters:
  - Byte counter is 10 bits. Terminal count 511 is compared on the stored index; there is no wrap past 511.
  - buf_addr is held at the last value between blocks.
- Frames arriving during NCR/RESP/data phases are not decoded. The host sends 0xFF there; other values are ignored.

Decomposition:
- Package spisd_pkg:
  - Command index constants CMD0, CMD8, CMD17, CMD24, CMD41, CMD55, CMD58.
  - Token constants: 0xFE start token, 0x05 data response.
  - R1 bit positions.
  - FSM state enum: HUNT, CMD, NCR, RESP, TAIL, GAP, RTOKEN, RDATA, RCRC, WTOKEN, WDATA, WCRC, DRESP, BUSY.
- Sub-module spisd_byte_slave:
  - Contains the synchronizers, sclk edge detection, rx/tx shift registers and bit counter.
  - Interface: rx_byte, rx_valid, tx_byte, cs_active.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 -> NCR 0xFF byte(s), then R1 0x01; idle=1.
- CMD8 arg 0x000001AA -> 01 00 00 01 AA.
- CMD55 + ACMD41, repeated -> responses 01, 01, 00 with INIT_POLLS=2; idle falls after the third pair. CMD58 then -> 00 C0 FF 80 00.
- CMD17 arg 0x00000200 after init, buffer preloaded with byte i = i[7:0] -> blk_rd_start pulse; blk_addr=0x200; stream 00, FF, FF, FE, 00..FF, 00..FF, FF, FF.
- CMD24 then FE + 512 bytes of 0xA5 + 2 CRC bytes -> 512 buf_wr pulses, blk_wr_done once, response 05 then 4x00 then FF. Deassert csn at write byte 100 -> no blk_wr_done; next CMD0 answered normally.
- CMD17 while idle=1 -> R1 0x05. Frame with stop bit 0 -> no response; the following valid CMD0 -> 0x01.
